// File: rtl/pos_codec_pkg.sv
// Shared types for the position-code encoder/decoder pair.
package pos_codec_pkg;

  localparam int POS_W = 2;
  localparam int OUT_W = 1 << POS_W;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [OUT_W-1:0] onehot_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } dec_state_e;

  // Expand a position code into its one-hot lane pattern.
  function automatic onehot_t pos_decode(input pos_t pos);
    return onehot_t'(1) << pos;
  endfunction

endpackage

// File: rtl/pos_fifo2.sv
// Two-entry synchronous FIFO with 1-bit read/write pointers and an
// occupancy count. Push when full and pop when empty are ignored.
module pos_fifo2 #(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  if (DEPTH != 2) begin : g_bad_depth
    $error("pos_fifo2: only DEPTH=2 is supported");
  end

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (count_q == 2'(DEPTH));
  assign empty_o = (count_q == 2'd0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count; reset discards any buffered entries.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pos_onehot_decoder.sv
// Buffers position codes in a 2-entry FIFO and drives each one as a
// one-hot strobe for HOLD_CYCLES cycles, back-to-back when codes are queued.
// Handshake: a code transfers on a rising edge when in_valid && in_ready;
// in_ready depends only on registered FIFO occupancy (never on a same-cycle
// pop) and is low while areset is high; in_pos is don't-care otherwise.
module pos_onehot_decoder
  import pos_codec_pkg::*;
#(
  parameter int POS_W       = pos_codec_pkg::POS_W,
  parameter int OUT_W       = pos_codec_pkg::OUT_W,
  parameter int HOLD_CYCLES = 2,
  parameter int DEPTH       = 2
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] in_pos,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_onehot,
  output logic             busy,
  output dec_state_e       dbg_state_o
);

  if (OUT_W != (1 << POS_W)) begin : g_bad_out_w
    $error("pos_onehot_decoder: OUT_W must equal 2**POS_W");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("pos_onehot_decoder: HOLD_CYCLES must be >= 1");
  end

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  dec_state_e       state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [OUT_W-1:0] onehot_q, onehot_d;
  logic             valid_q, valid_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [POS_W-1:0] fifo_head;
  logic [1:0]       fifo_count;

  assign in_ready  = !areset && !fifo_full;
  assign fifo_push = in_valid && in_ready;

  pos_fifo2 #(
    .W     (POS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .areset  (areset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (in_pos),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  // Next state: load from the FIFO head when idle or when a hold expires.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          onehot_d = OUT_W'(1) << fifo_head;
          valid_d  = 1'b1;
          hold_d   = CNT_W'(HOLD_CYCLES - 1);
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_q != '0) begin
          hold_d = hold_q - CNT_W'(1);
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          onehot_d = OUT_W'(1) << fifo_head;
          valid_d  = 1'b1;
          hold_d   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          onehot_d = '0;
          valid_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        onehot_d = '0;
        valid_d  = 1'b0;
        hold_d   = '0;
        state_d  = IDLE;
      end
    endcase
  end

  // State, hold counter and output registers; cleared asynchronously.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_onehot  = onehot_q;
  assign busy        = (state_q == DRIVE) || (fifo_count != 2'd0);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pos_onehot_decoder.sv
// Bench for pos_onehot_decoder: a HOLD_CYCLES=2 instance and a
// HOLD_CYCLES=1 instance, exercised one at a time.
module tb_pos_onehot_decoder;
  import pos_codec_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  logic       in_valid0, in_valid1;
  logic [1:0] in_pos0, in_pos1;
  logic       in_ready0, in_ready1;
  logic       out_valid0, out_valid1;
  logic [3:0] oh0, oh1;
  logic       busy0, busy1;
  dec_state_e st0, st1;

  pos_onehot_decoder #(.HOLD_CYCLES(2)) dut0 (
    .clk         (clk),
    .areset      (areset),
    .in_valid    (in_valid0),
    .in_ready    (in_ready0),
    .in_pos      (in_pos0),
    .out_valid   (out_valid0),
    .out_onehot  (oh0),
    .busy        (busy0),
    .dbg_state_o (st0)
  );

  pos_onehot_decoder #(.HOLD_CYCLES(1)) dut1 (
    .clk         (clk),
    .areset      (areset),
    .in_valid    (in_valid1),
    .in_ready    (in_ready1),
    .in_pos      (in_pos1),
    .out_valid   (out_valid1),
    .out_onehot  (oh1),
    .busy        (busy1),
    .dbg_state_o (st1)
  );

  logic       sel;
  logic       obs_ready, obs_valid, obs_busy;
  logic [3:0] obs_oh;
  assign obs_ready = sel ? in_ready1  : in_ready0;
  assign obs_valid = sel ? out_valid1 : out_valid0;
  assign obs_oh    = sel ? oh1        : oh0;
  assign obs_busy  = sel ? busy1      : busy0;

  // ---------------- reference model ----------------
  // Each accepted code gets a display window [start, start+hold) in edge
  // numbers: it starts one edge after acceptance, or when the previous
  // code's window ends, whichever is later.
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_hold = 2;
  int m_start[$];
  int m_code[$];

  function automatic int pending(input int e);
    int n = 0;
    foreach (m_start[i]) if (m_start[i] > e) n++;
    return n;
  endfunction

  function automatic int cur_code(input int e);
    int c = -1;
    foreach (m_start[i])
      if (m_start[i] <= e && e < m_start[i] + m_hold) c = m_code[i];
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called away from a clock edge; the whole task sits between two edges.
  task automatic do_reset();
    areset = 1'b1;
    #1;
    check("rst_onehot", 32'(obs_oh), 32'd0);
    check("rst_valid", 32'(obs_valid), 32'd0);
    check("rst_ready", 32'(obs_ready), 32'd0);
    check("rst_busy", 32'(obs_busy), 32'd0);
    m_start.delete();
    m_code.delete();
    #2;
    areset = 1'b0;
    #1;
    check("rel_ready", 32'(obs_ready), 32'd1);
  endtask

  // One clock: check ready, present (v,p), clock, update model, check outputs.
  task automatic tick(input logic v, input logic [1:0] p);
    bit rdy;
    int c;
    int st;
    rdy = (pending(cyc) < 2);
    check("in_ready", 32'(obs_ready), 32'(rdy));
    in_valid0 = v && !sel;
    in_valid1 = v && sel;
    in_pos0   = (v && !sel) ? p : 2'bxx;
    in_pos1   = (v && sel)  ? p : 2'bxx;
    @(posedge clk);
    cyc++;
    if (v && rdy) begin
      st = cyc + 1;
      if (m_start.size() > 0 && m_start[$] + m_hold > st) st = m_start[$] + m_hold;
      m_start.push_back(st);
      m_code.push_back(int'(p));
    end
    #1;
    c = cur_code(cyc);
    check("out_valid", 32'(obs_valid), (c >= 0) ? 32'd1 : 32'd0);
    check("out_onehot", 32'(obs_oh), (c >= 0) ? (32'd1 << c) : 32'd0);
    check("busy", 32'(obs_busy), ((c >= 0) || (pending(cyc) > 0)) ? 32'd1 : 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    sel       = 1'b0;
    m_hold    = 2;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    in_pos0   = 2'bxx;
    in_pos1   = 2'bxx;
    do_reset();

    // Single code 2: 0100 for two cycles, then idle.
    tick(1'b1, 2'd2);
    tick(1'b0, 2'd0);
    check("single_oh1", 32'(obs_oh), 32'h4);
    tick(1'b0, 2'd0);
    check("single_oh2", 32'(obs_oh), 32'h4);
    tick(1'b0, 2'd0);
    check("single_idle", 32'(obs_busy), 32'd0);

    // Back-to-back 0,1,3: FIFO fills after code 3, no output gaps.
    tick(1'b1, 2'd0);
    tick(1'b1, 2'd1);
    tick(1'b1, 2'd3);
    check("b2b_full", 32'(obs_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 2'd0);
      check("b2b_valid", 32'(obs_valid), 32'd1);
    end
    tick(1'b0, 2'd0);
    check("b2b_end", 32'(obs_valid), 32'd0);

    // Reset during first cycle of 0010 with code 3 queued: 3 must not appear.
    tick(1'b1, 2'd1);
    tick(1'b1, 2'd3);
    check("mid_oh", 32'(obs_oh), 32'h2);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 2'd0);
      check("mid_clear", 32'(obs_oh), 32'd0);
    end

    // Each code in isolation.
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, 2'(c));
      tick(1'b0, 2'd0);
      check("exh_oh", 32'(obs_oh), 32'd1 << c);
      tick(1'b0, 2'd0);
      tick(1'b0, 2'd0);
    end

    // Random traffic, HOLD_CYCLES=2.
    repeat (200) tick(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
    repeat (6) tick(1'b0, 2'd0);

    // HOLD_CYCLES=1 instance.
    sel    = 1'b1;
    m_hold = 1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 2'(3 - i));
      check("h1_ready", 32'(obs_ready), 32'd1);
    end
    tick(1'b0, 2'd0);
    check("h1_last", 32'(obs_oh), 32'h1);
    repeat (3) tick(1'b0, 2'd0);
    repeat (200) tick(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
    repeat (4) tick(1'b0, 2'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
